// File: rtl/fft_frame_sched_if.sv
// RAM-port and client handshake bundle for fft_frame_sched.
// The master modport is the scheduler; the slave modport is the client/RAM side.
interface fft_frame_sched_if #(
    parameter int N_LOG2 = 6,
    parameter int DATA_W = 16
);
    logic              enable;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;
    logic              cap_ready;
    logic              br_start;
    logic              br_done;
    logic [N_LOG2-1:0] br_addrA, br_addrB;
    logic [DATA_W-1:0] br_dinA, br_dinB;
    logic              br_weA, br_weB;
    logic [N_LOG2-1:0] cons_addr;
    logic              frame_ready;
    logic              frame_release;
    logic [N_LOG2-1:0] ram_addrA, ram_addrB;
    logic [DATA_W-1:0] ram_dinA, ram_dinB;
    logic              ram_weA, ram_weB;

    modport master (
        input  enable, cap_valid, cap_data, br_done, br_addrA, br_addrB,
               br_dinA, br_dinB, br_weA, br_weB, cons_addr, frame_release,
        output cap_ready, br_start, frame_ready, ram_addrA, ram_addrB,
               ram_dinA, ram_dinB, ram_weA, ram_weB
    );

    modport slave (
        output enable, cap_valid, cap_data, br_done, br_addrA, br_addrB,
               br_dinA, br_dinB, br_weA, br_weB, cons_addr, frame_release,
        input  cap_ready, br_start, frame_ready, ram_addrA, ram_addrB,
               ram_dinA, ram_dinB, ram_weA, ram_weB
    );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame sequencer / dual-port RAM arbiter: capture -> bit-reverse -> consumer handoff.
// Optional FFT_OVERRUN_CNT_EN adds a saturating back-pressure overrun counter.
module fft_frame_sched #(
    parameter int N_LOG2 = 6,
    parameter int DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fft_frame_sched_if.master   bus,
`ifdef FFT_OVERRUN_CNT_EN
    output logic [15:0]         overrun_cnt_o,
`endif
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, REORDER = 2'd2, HANDOFF = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] wcnt_q, wcnt_d;
    logic              first_q, first_d;
    logic              cap_ready_w;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: if (bus.enable) begin
                state_d = CAPTURE;
                wcnt_d  = '0;
            end
            CAPTURE: if (bus.cap_valid) begin
                wcnt_d = wcnt_q + 1'b1;
                if (&wcnt_q) begin
                    state_d = REORDER;
                    first_d = 1'b1;
                end
            end
            // first_q masks a stale done from the previous pass in the start cycle
            REORDER: if (!first_q && bus.br_done) state_d = HANDOFF;
            HANDOFF: if (bus.frame_release) begin
                wcnt_d  = '0;
                state_d = bus.enable ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap_ready_w     = (state_q == CAPTURE);
    assign bus.cap_ready   = cap_ready_w;
    assign bus.br_start    = (state_q == REORDER) && first_q;
    assign bus.frame_ready = (state_q == HANDOFF);
    assign state_o         = state_q;

    always_comb begin
        bus.ram_addrA = '0;
        bus.ram_addrB = '0;
        bus.ram_dinA  = '0;
        bus.ram_dinB  = '0;
        bus.ram_weA   = 1'b0;
        bus.ram_weB   = 1'b0;
        case (state_q)
            CAPTURE: begin
                bus.ram_addrA = wcnt_q;
                bus.ram_dinA  = bus.cap_data;
                bus.ram_weA   = bus.cap_valid;
            end
            REORDER: begin
                bus.ram_addrA = bus.br_addrA;
                bus.ram_addrB = bus.br_addrB;
                bus.ram_dinA  = bus.br_dinA;
                bus.ram_dinB  = bus.br_dinB;
                bus.ram_weA   = bus.br_weA;
                bus.ram_weB   = bus.br_weB;
            end
            HANDOFF: bus.ram_addrB = bus.cons_addr;
            default: ;
        endcase
    end

`ifdef FFT_OVERRUN_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (state_q == IDLE && state_d == CAPTURE)
            ovr_d = '0;
        else if (state_q != IDLE && bus.cap_valid && !cap_ready_w && ovr_q != 16'hFFFF)
            ovr_d = ovr_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovr_q <= '0;
        else         ovr_q <= ovr_d;
    end

    assign overrun_cnt_o = ovr_q;
`endif
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched with an 8-sample frame.
module tb_fft_frame_sched;
    localparam int N = 3;
    localparam int W = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] state_o;
`ifdef FFT_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_o;
`endif
    int checks = 0;
    int errors = 0;

    fft_frame_sched_if #(.N_LOG2(N), .DATA_W(W)) bus ();

    fft_frame_sched #(.N_LOG2(N), .DATA_W(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (bus.master),
`ifdef FFT_OVERRUN_CNT_EN
        .overrun_cnt_o (overrun_cnt_o),
`endif
        .state_o (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        bus.enable = 0; bus.cap_valid = 0; bus.cap_data = '0; bus.br_done = 0;
        bus.br_addrA = '0; bus.br_addrB = '0; bus.br_dinA = '0; bus.br_dinB = '0;
        bus.br_weA = 0; bus.br_weB = 0; bus.cons_addr = '0; bus.frame_release = 0;
        #12;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_cap_ready", 32'(bus.cap_ready), 0);
        chk("rst_br_start", 32'(bus.br_start), 0);
        chk("rst_frame_ready", 32'(bus.frame_ready), 0);
        chk("rst_weA", 32'(bus.ram_weA), 0);
        chk("rst_weB", 32'(bus.ram_weB), 0);
        chk("rst_addrA", 32'(bus.ram_addrA), 0);
        chk("rst_addrB", 32'(bus.ram_addrB), 0);
        chk("rst_dinA", 32'(bus.ram_dinA), 0);
        chk("rst_dinB", 32'(bus.ram_dinB), 0);
`ifdef FFT_OVERRUN_CNT_EN
        chk("rst_ovr", 32'(overrun_cnt_o), 0);
`endif

        rst_ni = 1'b1; bus.enable = 1'b1;
        step();
        chk("cap_state", 32'(state_o), 1);
        chk("cap_ready", 32'(bus.cap_ready), 1);
        // drop enable mid-frame and raise a stray done: neither may disturb the frame
        bus.enable = 1'b0; bus.br_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.cap_valid = 1'b1; bus.cap_data = 16'h10 + 16'(i);
            #1;
            chk("cap_weA", 32'(bus.ram_weA), 1);
            chk("cap_addrA", 32'(bus.ram_addrA), 32'(i));
            chk("cap_dinA", 32'(bus.ram_dinA), 32'h10 + 32'(i));
            chk("cap_weB", 32'(bus.ram_weB), 0);
            chk("cap_state_hold", 32'(state_o), 1);
            step();
        end

        bus.cap_valid = 1'b0;
        bus.br_addrA = 3'd5; bus.br_dinA = 16'hAAAA; bus.br_weA = 1'b1;
        #1;
        chk("reo_state", 32'(state_o), 2);
        chk("reo_br_start", 32'(bus.br_start), 1);
        chk("reo_cap_ready", 32'(bus.cap_ready), 0);
        chk("reo_addrA", 32'(bus.ram_addrA), 5);
        chk("reo_dinA", 32'(bus.ram_dinA), 32'hAAAA);
        chk("reo_weA", 32'(bus.ram_weA), 1);
        step();
        chk("reo_first_done_ignored", 32'(state_o), 2);
        chk("reo_br_start_low", 32'(bus.br_start), 0);
        bus.br_done = 1'b0; bus.br_weA = 1'b0;
        repeat (10) step();
        chk("reo_wait", 32'(state_o), 2);
        chk("reo_frame_ready_low", 32'(bus.frame_ready), 0);
        bus.br_done = 1'b1;
        step();
        chk("ho_state", 32'(state_o), 3);
        chk("ho_frame_ready", 32'(bus.frame_ready), 1);
        chk("ho_cap_ready", 32'(bus.cap_ready), 0);
        bus.br_done = 1'b0;

        bus.br_weA = 1'b1; bus.br_weB = 1'b1; bus.br_addrA = 3'd3; bus.cap_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.cons_addr = 3'(i);
            #1;
            chk("ho_weA", 32'(bus.ram_weA), 0);
            chk("ho_weB", 32'(bus.ram_weB), 0);
            chk("ho_addrB", 32'(bus.ram_addrB), 32'(i % 8));
            chk("ho_addrA", 32'(bus.ram_addrA), 0);
            step();
        end
        bus.cap_valid = 1'b0; bus.br_weA = 1'b0; bus.br_weB = 1'b0;
`ifdef FFT_OVERRUN_CNT_EN
        #1;
        chk("ovr_20", 32'(overrun_cnt_o), 20);
`endif
        bus.frame_release = 1'b1;
        step();
        chk("rel_idle", 32'(state_o), 0);
        chk("rel_frame_ready", 32'(bus.frame_ready), 0);
        bus.frame_release = 1'b0;

        bus.enable = 1'b1;
        step();
        chk("re_cap_state", 32'(state_o), 1);
`ifdef FFT_OVERRUN_CNT_EN
        chk("ovr_cleared", 32'(overrun_cnt_o), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            bus.cap_valid = 1'b1; bus.cap_data = 16'h20 + 16'(i);
            step();
        end
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 0);
        chk("arst_cap_ready", 32'(bus.cap_ready), 0);
        chk("arst_weA", 32'(bus.ram_weA), 0);
        chk("arst_addrA", 32'(bus.ram_addrA), 0);
        chk("arst_dinA", 32'(bus.ram_dinA), 0);
        #1;
        rst_ni = 1'b1; bus.cap_valid = 1'b0;
        step();
        chk("restart_state", 32'(state_o), 1);
        for (int i = 0; i < 8; i++) begin
            bus.cap_valid = 1'b1; bus.cap_data = 16'h30 + 16'(i);
            #1;
            chk("restart_addrA", 32'(bus.ram_addrA), 32'(i));
            chk("restart_dinA", 32'(bus.ram_dinA), 32'h30 + 32'(i));
            step();
        end
        bus.cap_valid = 1'b0; bus.br_done = 1'b1;
        step();
        chk("f2_first_ignored", 32'(state_o), 2);
        step();
        chk("f2_handoff", 32'(state_o), 3);
        bus.br_done = 1'b0; bus.frame_release = 1'b1;
        step();
        chk("f2_recapture", 32'(state_o), 1);
        chk("f2_cap_ready", 32'(bus.cap_ready), 1);
        chk("f2_frame_ready", 32'(bus.frame_ready), 0);
        bus.frame_release = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
